sr_pulse_driver: RTL

SR_PULSE_DRIVER -- requirements
Module: sr_pulse_driver

---
 rtl/sr_pkg.sv | 26 ++
 rtl/sr_pulse_timer.sv | 27 ++
 rtl/sr_pulse_driver.sv | 171 +++++++++++++++++
 3 files changed

// File: rtl/sr_pkg.sv
// Shared types and constants for the SR latch pulse driver.
// Holds the FSM state enum, the counter width and the pulse-width clamp helper.
package sr_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2,
        CHECK = 2'd3
    } state_t;

    // Out-of-range widths are forced into 1..15 so the loaded count can never wrap.
    function automatic logic [CNT_W-1:0] clamp_w(input int w);
        int c;
        c = w;
        if (c < 1) begin
            c = 1;
        end else if (c > 15) begin
            c = 15;
        end
        return c[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter that saturates at zero; done is high while the count is zero.
module sr_pulse_timer
    import sr_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/sr_pulse_driver.sv
// Drives timed S/R pulses and the gate into a gated SR latch, with an idle gap after each pulse.
// Optional readback check of the latch Q is enabled by defining SR_READBACK_CHECK_EN.
module sr_pulse_driver
    import sr_pkg::*;
#(
    parameter int PULSE_W = 2,
    parameter int GAP_W   = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cmd_valid,
    input  logic cmd_set,
    output logic cmd_ready,
    output logic s_out,
    output logic r_out,
    output logic gate,
    input  logic q_in,
    output logic err
);

    localparam logic [CNT_W-1:0] PULSE_LD = clamp_w(PULSE_W) - CNT_W'(1);
    localparam logic [CNT_W-1:0] GAP_LD   = clamp_w(GAP_W) - CNT_W'(1);

    state_t           state;
    logic             t_load;
    logic [CNT_W-1:0] t_load_val;
    logic             t_dec;
    logic             t_done;

    // Handshake: a command transfers on a rising edge where cmd_valid and cmd_ready are
    // both high; cmd_ready is high only in IDLE, and inputs seen in any other state are dropped.
    always_comb begin
        t_load     = 1'b0;
        t_load_val = PULSE_LD;
        t_dec      = 1'b0;
        case (state)
            IDLE: begin
                t_load     = cmd_valid;
                t_load_val = PULSE_LD;
            end
            PULSE: begin
                t_load     = t_done;
                t_load_val = GAP_LD;
                t_dec      = 1'b1;
            end
            GAP: begin
                t_dec = 1'b1;
            end
            default: begin
                t_load = 1'b0;
            end
        endcase
    end

    sr_pulse_timer u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (t_load),
        .load_val (t_load_val),
        .dec      (t_dec),
        .done     (t_done)
    );

`ifdef SR_READBACK_CHECK_EN
    logic set_q;
    logic err_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            set_q     <= 1'b0;
            err_q     <= 1'b0;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            gate      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= PULSE;
                        set_q     <= cmd_set;
                        s_out     <= cmd_set;
                        r_out     <= ~cmd_set;
                        gate      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                PULSE: begin
                    if (t_done) begin
                        state <= GAP;
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                        gate  <= 1'b0;
                    end
                end
                GAP: begin
                    if (t_done) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (q_in != set_q) begin
                        err_q <= 1'b1;
                    end
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    s_out     <= 1'b0;
                    r_out     <= 1'b0;
                    gate      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = q_in;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            s_out     <= 1'b0;
            r_out     <= 1'b0;
            gate      <= 1'b0;
            cmd_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        state     <= PULSE;
                        s_out     <= cmd_set;
                        r_out     <= ~cmd_set;
                        gate      <= 1'b1;
                        cmd_ready <= 1'b0;
                    end
                end
                PULSE: begin
                    if (t_done) begin
                        state <= GAP;
                        s_out <= 1'b0;
                        r_out <= 1'b0;
                        gate  <= 1'b0;
                    end
                end
                GAP: begin
                    if (t_done) begin
                        state     <= IDLE;
                        cmd_ready <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    s_out     <= 1'b0;
                    r_out     <= 1'b0;
                    gate      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
            endcase
        end
    end

    assign err = 1'b0;
`endif

endmodule
